// File: rtl/alu_result_bank_pkg.sv
// Shared constants and source-select encoding for the ALU result bank.
package alu_result_bank_pkg;

  localparam int unsigned WIDTH_DEF = 16;
  localparam int unsigned DEPTH_DEF = 4;
  localparam int unsigned IDX_W_DEF = $clog2(DEPTH_DEF);

  // Which source, if any, commits a value this cycle.
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_ALU  = 2'd1,
    SRC_ALT  = 2'd2
  } src_e;

endpackage

// File: rtl/alu_result_bank_button_sync_edge.sv
// Synchronises an asynchronous level input and emits a one-cycle pulse on
// each rising edge. Shared by the front-panel inputs.
module button_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic async_in,
  output logic rise_pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Synchroniser chain followed by a single history flop for edge detect.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise_pulse = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/alu_result_bank.sv
// Current ALU/alternate result register with a DEPTH-entry ring-buffer
// history that can be stepped through for display.
module alu_result_bank
  import alu_result_bank_pkg::*;
#(
  parameter int unsigned WIDTH       = WIDTH_DEF,
  parameter int unsigned DEPTH       = DEPTH_DEF,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       load_alu,
  input  logic                       load_alt,
  input  logic                       button,
  input  logic [WIDTH-1:0]           alu_in,
  input  logic [WIDTH-1:0]           alt_in,
  input  logic                       view_step,
  output logic [WIDTH-1:0]           outs,
  output logic [WIDTH-1:0]           view_out,
  output logic [$clog2(DEPTH)-1:0]   view_idx,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       pushed
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = IDX_W + 1;

  logic             btn_rise;
  src_e             src;
  logic [WIDTH-1:0] commit_val;

  logic [WIDTH-1:0] outs_q,     outs_d;
  logic [IDX_W-1:0] wr_ptr_q,   wr_ptr_d;
  logic [CNT_W-1:0] count_q,    count_d;
  logic [IDX_W-1:0] view_idx_q, view_idx_d;
  logic             pushed_q,   pushed_d;
  logic [WIDTH-1:0] hist_q [DEPTH];
  logic [IDX_W-1:0] rd_ptr;

  button_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_btn (
    .clock      (clock),
    .reset      (reset),
    .async_in   (button),
    .rise_pulse (btn_rise)
  );

  // Commit source select: ALU load outranks a qualified button press, and a
  // press that loses to the ALU (or arrives without load_alt) is dropped.
  always_comb begin
    src        = SRC_NONE;
    commit_val = '0;
    if (load_alu) begin
      src = SRC_ALU;
    end else if (btn_rise && load_alt) begin
      src = SRC_ALT;
    end
    unique case (src)
      SRC_ALU: commit_val = alu_in;
      SRC_ALT: commit_val = alt_in;
      default: commit_val = '0;
    endcase
  end

  // Next-state for result, pointers, fill count and view position.
  always_comb begin
    outs_d     = outs_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    view_idx_d = view_idx_q;
    pushed_d   = 1'b0;
    if (src != SRC_NONE) begin
      outs_d     = commit_val;
      wr_ptr_d   = wr_ptr_q + IDX_W'(1);
      count_d    = (count_q == CNT_W'(DEPTH)) ? count_q : count_q + CNT_W'(1);
      view_idx_d = '0;
      pushed_d   = 1'b1;
    end else if (view_step) begin
      if (count_q == '0) begin
        view_idx_d = '0;
      end else if ({1'b0, view_idx_q} == count_q - CNT_W'(1)) begin
        view_idx_d = '0;
      end else begin
        view_idx_d = view_idx_q + IDX_W'(1);
      end
    end
  end

  // Control and result registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      outs_q     <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      view_idx_q <= '0;
      pushed_q   <= 1'b0;
    end else begin
      outs_q     <= outs_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      view_idx_q <= view_idx_d;
      pushed_q   <= pushed_d;
    end
  end

  // History storage; the write slot is the current write pointer.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        hist_q[i] <= '0;
      end
    end else if (src != SRC_NONE) begin
      hist_q[wr_ptr_q] <= commit_val;
    end
  end

  // Newest entry sits one behind the write pointer; DEPTH is a power of two
  // so the pointer subtraction wraps naturally.
  assign rd_ptr   = wr_ptr_q - IDX_W'(1) - view_idx_q;
  assign view_out = (count_q == '0) ? '0 : hist_q[rd_ptr];

  assign outs     = outs_q;
  assign view_idx = view_idx_q;
  assign count    = count_q;
  assign pushed   = pushed_q;

endmodule

// File: tb/tb_alu_result_bank.sv
// Scoreboard bench for alu_result_bank with directed vectors.
module tb_alu_result_bank;

  logic        clock;
  logic        reset;
  logic        load_alu;
  logic        load_alt;
  logic        button;
  logic [15:0] alu_in;
  logic [15:0] alt_in;
  logic        view_step;
  logic [15:0] outs;
  logic [15:0] view_out;
  logic [1:0]  view_idx;
  logic [2:0]  count;
  logic        pushed;

  typedef struct {
    logic [15:0] v;
    logic [2:0]  c;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   mcount = 0;

  alu_result_bank #(
    .WIDTH       (16),
    .DEPTH       (4),
    .SYNC_STAGES (2)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .load_alu  (load_alu),
    .load_alt  (load_alt),
    .button    (button),
    .alu_in    (alu_in),
    .alt_in    (alt_in),
    .view_step (view_step),
    .outs      (outs),
    .view_out  (view_out),
    .view_idx  (view_idx),
    .count     (count),
    .pushed    (pushed)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_push(input logic [15:0] v);
    exp_t e;
    mcount = (mcount == 4) ? 4 : mcount + 1;
    e.v = v;
    e.c = 3'(mcount);
    q.push_back(e);
  endtask

  task automatic commit_alu(input logic [15:0] v);
    alu_in   = v;
    load_alu = 1'b1;
    expect_push(v);
    cyc();
    load_alu = 1'b0;
  endtask

  task automatic step_view();
    view_step = 1'b1;
    cyc();
    view_step = 1'b0;
  endtask

  // Monitor: every push must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (reset === 1'b1 && pushed === 1'b1) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_push: got outs=%h expected no push", outs);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("push_outs", 32'(outs), 32'(e.v));
        check("push_count", 32'(count), 32'(e.c));
        check("push_view_idx", 32'(view_idx), 32'd0);
        check("push_view_out", 32'(view_out), 32'(e.v));
      end
    end
  end

  initial begin
    logic [15:0] walk [4];
    reset = 1'b0; load_alu = 1'b0; load_alt = 1'b0; button = 1'b0;
    alu_in = '0; alt_in = '0; view_step = 1'b0;

    #23;
    check("rst_outs", 32'(outs), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_view_idx", 32'(view_idx), 32'd0);
    check("rst_view_out", 32'(view_out), 32'd0);
    check("rst_pushed", 32'(pushed), 32'd0);
    #4 reset = 1'b1;
    cyc();

    // Single ALU commit
    commit_alu(16'h1234);
    check("alu_outs", 32'(outs), 32'h1234);
    check("alu_pushed", 32'(pushed), 32'd1);
    check("alu_count", 32'(count), 32'd1);
    cyc();
    check("alu_pushed_drop", 32'(pushed), 32'd0);

    // Held button with load_alt: one commit, SYNC_STAGES+1 edges after rise
    alt_in   = 16'h00AA;
    load_alt = 1'b1;
    button   = 1'b1;
    expect_push(16'h00AA);
    cyc();
    cyc();
    check("btn_not_early", 32'(outs), 32'h1234);
    cyc();
    check("btn_outs", 32'(outs), 32'h00AA);
    check("btn_count", 32'(count), 32'd2);
    repeat (8) cyc();
    button   = 1'b0;
    load_alt = 1'b0;
    repeat (4) cyc();
    check("btn_held_count", 32'(count), 32'd2);

    // Press without load_alt is dropped, not queued
    button = 1'b1;
    repeat (6) cyc();
    button = 1'b0;
    repeat (4) cyc();
    check("drop_outs", 32'(outs), 32'h00AA);
    check("drop_count", 32'(count), 32'd2);
    load_alt = 1'b1;
    repeat (4) cyc();
    load_alt = 1'b0;
    check("drop_late_outs", 32'(outs), 32'h00AA);
    check("drop_late_count", 32'(count), 32'd2);

    // Fill and overflow the history
    for (int i = 1; i <= 5; i++) commit_alu(16'(i));
    check("full_count", 32'(count), 32'd4);
    check("view0", 32'(view_out), 32'd5);
    walk[0] = 16'd4; walk[1] = 16'd3; walk[2] = 16'd2; walk[3] = 16'd5;
    for (int i = 0; i < 4; i++) begin
      step_view();
      check($sformatf("view_walk%0d", i), 32'(view_out), 32'(walk[i]));
      check($sformatf("view_idx%0d", i), 32'(view_idx), 32'((i + 1) % 4));
    end
    step_view();
    check("pre_combo_idx", 32'(view_idx), 32'd1);

    // ALU, qualified press and view_step in one cycle
    button = 1'b1;
    cyc();
    cyc();
    alu_in = 16'h0007; load_alu = 1'b1;
    alt_in = 16'h0009; load_alt = 1'b1;
    view_step = 1'b1;
    expect_push(16'h0007);
    cyc();
    load_alu = 1'b0; view_step = 1'b0;
    check("combo_outs", 32'(outs), 32'h0007);
    check("combo_idx", 32'(view_idx), 32'd0);
    repeat (4) cyc();
    check("combo_consumed", 32'(outs), 32'h0007);
    load_alt = 1'b0;
    button   = 1'b0;
    repeat (4) cyc();

    // Async reset mid-history
    reset = 1'b0; #2 reset = 1'b1; mcount = 0;
    cyc();
    commit_alu(16'h0011);
    commit_alu(16'h0022);
    commit_alu(16'h0033);
    step_view();
    step_view();
    check("pre_rst_idx", 32'(view_idx), 32'd2);
    check("pre_rst_view", 32'(view_out), 32'h0011);
    #3 reset = 1'b0;
    #1;
    check("mid_rst_outs", 32'(outs), 32'd0);
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_idx", 32'(view_idx), 32'd0);
    check("mid_rst_view", 32'(view_out), 32'd0);
    mcount = 0;
    #2 reset = 1'b1;
    cyc();
    commit_alu(16'h0055);
    check("post_rst_count", 32'(count), 32'd1);
    step_view();
    check("single_wrap_idx", 32'(view_idx), 32'd0);

    repeat (3) cyc();
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
